// File: rtl/acc_cpu_pkg.sv
// acc_cpu_pkg: shared opcode, state and flag constants
// for the accumulator core and its bench.
package acc_cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_OUT  = 4'h6;
  localparam logic [3:0] OP_LOAD = 4'h7;
  localparam logic [3:0] OP_ADDM = 4'h8;
  localparam logic [3:0] OP_ANDI = 4'h9;
  localparam logic [3:0] OP_ORI  = 4'hA;
  localparam logic [3:0] OP_XORI = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_RET  = 4'hF;

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

endpackage

// File: rtl/acc_cpu_if.sv
// acc_cpu_if: memory-mapped bus between the core (master)
// and the SoC slaves; valid/ready handshake.
interface acc_cpu_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) ();

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              we;
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (
    output addr, wdata, we, valid,
    input  ready, rdata
  );

  modport slave (
    input  addr, wdata, we, valid,
    output ready, rdata
  );

endinterface

// File: rtl/acc_cpu_rstack.sv
// acc_cpu_rstack: LIFO return stack, DEPTH x W,
// top-of-stack visible combinationally on dout.
module acc_cpu_rstack #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign dout  = mem[AW'(cnt - CW'(1))];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (push) begin
      mem[AW'(cnt)] <= din;
      cnt           <= cnt + CW'(1);
    end else if (pop) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/acc_cpu_p.sv
// acc_cpu_p: parametrised accumulator core with stalling bus master.
// Define ACC_CPU_STACK_EN to enable CALL/RET with a return stack.
module acc_cpu_p
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int OPND_W      = 8,
  parameter int PC_W        = 8,
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [OPND_W+3:0] imem_data,
  acc_cpu_if.master         bus,
  output logic              halted,
  output logic              fault,
  output logic [DATA_W-1:0] acc_out,
  output logic [PC_W-1:0]   pc_out
);

  logic [1:0]        state;
  logic [OPND_W+3:0] ir;
  logic [DATA_W-1:0] acc;
  logic [PC_W-1:0]   pc;
  logic [1:0]        flags;

  logic [3:0]        opc;
  logic [OPND_W-1:0] opnd;
  logic [DATA_W-1:0] imm;
  logic [PC_W-1:0]   pc_inc;
  logic [PC_W-1:0]   target;
  logic [DATA_W:0]   addi_sum;
  logic [DATA_W:0]   subi_dif;
  logic [DATA_W:0]   addm_sum;
  logic [DATA_W-1:0] and_res;
  logic [DATA_W-1:0] or_res;
  logic [DATA_W-1:0] xor_res;

  assign opc      = ir[OPND_W +: 4];
  assign opnd     = ir[OPND_W-1:0];
  assign imm      = DATA_W'(opnd);
  assign target   = PC_W'(opnd);
  assign pc_inc   = pc + PC_W'(1);
  assign addi_sum = {1'b0, acc} + {1'b0, imm};
  assign subi_dif = {1'b0, acc} - {1'b0, imm};
  assign addm_sum = {1'b0, acc} + {1'b0, bus.rdata};
  assign and_res  = acc & imm;
  assign or_res   = acc | imm;
  assign xor_res  = acc ^ imm;

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign acc_out   = acc;

`ifdef ACC_CPU_STACK_EN
  logic            push;
  logic            pop;
  logic            stk_full;
  logic            stk_empty;
  logic            stk_err;
  logic [PC_W-1:0] stk_top;
  logic            exec;

  assign exec    = (state == ST_EXEC);
  assign push    = exec && (opc == OP_CALL) && !stk_full;
  assign pop     = exec && (opc == OP_RET) && !stk_empty;
  assign stk_err = exec &&
                   (((opc == OP_CALL) && stk_full) ||
                    ((opc == OP_RET) && stk_empty));

  acc_cpu_rstack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_rstack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (pc_inc),
    .dout  (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fault <= 1'b0;
    end else if (stk_err) begin
      fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      ir        <= '0;
      acc       <= '0;
      pc        <= '0;
      flags     <= '0;
      halted    <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
      bus.we    <= 1'b0;
      bus.valid <= 1'b0;
    end else begin
      unique case (state)
        ST_FETCH: begin
          ir    <= imem_data;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          state <= ST_FETCH;
          pc    <= pc_inc;
          unique case (opc)
            OP_LDI: begin
              acc           <= imm;
              flags[FLAG_Z] <= (imm == '0);
            end
            OP_ADDI: begin
              acc           <= addi_sum[DATA_W-1:0];
              flags[FLAG_C] <= addi_sum[DATA_W];
              flags[FLAG_Z] <= (addi_sum[DATA_W-1:0] == '0);
            end
            OP_SUBI: begin
              acc           <= subi_dif[DATA_W-1:0];
              flags[FLAG_C] <= subi_dif[DATA_W];
              flags[FLAG_Z] <= (subi_dif[DATA_W-1:0] == '0);
            end
            OP_ANDI: begin
              acc           <= and_res;
              flags[FLAG_Z] <= (and_res == '0);
            end
            OP_ORI: begin
              acc           <= or_res;
              flags[FLAG_Z] <= (or_res == '0);
            end
            OP_XORI: begin
              acc           <= xor_res;
              flags[FLAG_Z] <= (xor_res == '0);
            end
            OP_JMP: pc <= target;
            OP_JZ:  if (flags[FLAG_Z]) pc <= target;
            OP_JC:  if (flags[FLAG_C]) pc <= target;
            OP_OUT: begin
              bus.addr  <= ADDR_W'(opnd);
              bus.wdata <= acc;
              bus.we    <= 1'b1;
              bus.valid <= 1'b1;
              state     <= ST_WAIT;
            end
            OP_LOAD, OP_ADDM: begin
              bus.addr  <= ADDR_W'(opnd);
              bus.we    <= 1'b0;
              bus.valid <= 1'b1;
              state     <= ST_WAIT;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= ST_HALT;
            end
`ifdef ACC_CPU_STACK_EN
            // Stack errors freeze pc on the faulting instruction.
            OP_CALL: begin
              if (stk_full) begin
                pc     <= pc;
                halted <= 1'b1;
                state  <= ST_HALT;
              end else begin
                pc <= target;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                pc     <= pc;
                halted <= 1'b1;
                state  <= ST_HALT;
              end else begin
                pc <= stk_top;
              end
            end
`endif
            default: ;
          endcase
        end
        ST_WAIT: begin
          if (bus.ready) begin
            bus.valid <= 1'b0;
            state     <= ST_FETCH;
            if (!bus.we) begin
              if (opc == OP_ADDM) begin
                acc           <= addm_sum[DATA_W-1:0];
                flags[FLAG_C] <= addm_sum[DATA_W];
                flags[FLAG_Z] <= (addm_sum[DATA_W-1:0] == '0);
              end else begin
                acc           <= bus.rdata;
                flags[FLAG_Z] <= (bus.rdata == '0);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
